// File: rtl/icache.sv
// Direct-mapped instruction cache: one 32-bit word per line, single outstanding
// request, miss refill through a valid/enable handshake with the memory controller.
//
// state  | meaning
// S_IDLE | waiting for a fetch; hits are answered from the array
// S_MISS | mem_valid raised, waiting for the memory controller's mem_enable
module icache #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ifu_valid,
    input  logic [31:0] ifu_pc,
    input  logic        flush,
    output logic        ifu_ready,
    output logic [31:0] ifu_inst,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_enable,
    input  logic [31:0] mem_data
);

    localparam int TAG_WIDTH = 16 - INDEX_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;

    typedef enum logic {S_IDLE, S_MISS} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]     valid_q;
    logic [TAG_WIDTH-1:0] tag_mem  [LINES];
    logic [31:0]          data_mem [LINES];

    logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
    logic [TAG_WIDTH-1:0]   req_tag, fill_tag;
    logic                   hit, accept, fill;
    logic                   unused_pc;

    logic        ready_d, mem_valid_d;
    logic [31:0] inst_d, mem_addr_d;

    assign req_idx   = ifu_pc[INDEX_WIDTH+1:2];
    assign req_tag   = ifu_pc[17:INDEX_WIDTH+2];
    // The refill target comes from the registered miss address, not the live pc.
    assign fill_idx  = mem_addr[INDEX_WIDTH+1:2];
    assign fill_tag  = mem_addr[17:INDEX_WIDTH+2];
    assign unused_pc = ^ifu_pc[1:0];

    assign hit    = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign accept = rdy && !flush && (state_q == S_IDLE) && ifu_valid && !ifu_ready;
    assign fill   = rdy && !flush && (state_q == S_MISS) && mem_enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            if (flush) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (accept && !hit) state_d = S_MISS;
                    S_MISS: if (mem_enable) state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        ready_d     = ifu_ready;
        inst_d      = ifu_inst;
        mem_valid_d = mem_valid;
        mem_addr_d  = mem_addr;
        if (rdy) begin
            ready_d = 1'b0;
            if (flush) begin
                mem_valid_d = 1'b0;
            end else if (accept) begin
                if (hit) begin
                    ready_d = 1'b1;
                    inst_d  = data_mem[req_idx];
                end else begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = {ifu_pc[31:2], 2'b00};
                end
            end else if (fill) begin
                ready_d     = 1'b1;
                inst_d      = mem_data;
                mem_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifu_ready <= 1'b0;
            ifu_inst  <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            valid_q   <= '0;
        end else begin
            ifu_ready <= ready_d;
            ifu_inst  <= inst_d;
            mem_valid <= mem_valid_d;
            mem_addr  <= mem_addr_d;
            if (fill) valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed plus randomized bench for icache with a line-level cache model and
// a backing-memory model driving the memory-controller side.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        ifu_valid = 1'b0;
    logic [31:0] ifu_pc = '0;
    logic        flush = 1'b0;
    logic        ifu_ready;
    logic [31:0] ifu_inst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_enable = 1'b0;
    logic [31:0] mem_data = '0;

    int errors = 0;
    int checks = 0;

    // Cache model for INDEX_WIDTH=6: index pc[7:2], tag pc[17:8].
    bit          mv [64];
    logic [9:0]  mt [64];
    logic [31:0] md [64];
    logic [31:0] bmem [int];

    icache #(.INDEX_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .ifu_valid(ifu_valid), .ifu_pc(ifu_pc),
        .flush(flush), .ifu_ready(ifu_ready), .ifu_inst(ifu_inst),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_enable(mem_enable), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int key = int'(a[17:2]);
        if (bmem.exists(key)) return bmem[key];
        return {a[17:2] ^ 16'h5A3C, ~a[17:2]};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; ifu_valid = 1'b0; flush = 1'b0; mem_enable = 1'b0; rdy = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ifu_ready}, 32'd0);
        chk("rst_inst", ifu_inst, 32'd0);
        chk("rst_mvalid", {31'b0, mem_valid}, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        rst = 1'b1;
        step();
    endtask

    // One complete fetch; the IFU keeps ifu_valid high through the ready
    // cycle to confirm the pulse blocks re-acceptance.
    task automatic fetch(input logic [31:0] pc, input int lat);
        logic [5:0]  idx = pc[7:2];
        logic [9:0]  tg  = pc[17:8];
        bit          hit = mv[idx] && (mt[idx] == tg);
        logic [31:0] exp = hit ? md[idx] : mem_word(pc);
        ifu_valid = 1'b1;
        ifu_pc = pc;
        step();
        if (hit) begin
            chk("hit_ready", {31'b0, ifu_ready}, 32'd1);
            chk("hit_inst", ifu_inst, exp);
            chk("hit_mvalid", {31'b0, mem_valid}, 32'd0);
        end else begin
            chk("miss_mvalid", {31'b0, mem_valid}, 32'd1);
            chk("miss_maddr", mem_addr, {pc[31:2], 2'b00});
            chk("miss_ready", {31'b0, ifu_ready}, 32'd0);
            for (int i = 0; i < lat; i++) begin
                step();
                chk("wait_mvalid", {31'b0, mem_valid}, 32'd1);
                chk("wait_maddr", mem_addr, {pc[31:2], 2'b00});
                chk("wait_ready", {31'b0, ifu_ready}, 32'd0);
            end
            mem_enable = 1'b1;
            mem_data = exp;
            step();
            mem_enable = 1'b0;
            mem_data = $urandom;
            chk("fill_ready", {31'b0, ifu_ready}, 32'd1);
            chk("fill_inst", ifu_inst, exp);
            chk("fill_mvalid", {31'b0, mem_valid}, 32'd0);
            mv[idx] = 1'b1; mt[idx] = tg; md[idx] = exp;
        end
        step();
        chk("noreaccept_ready", {31'b0, ifu_ready}, 32'd0);
        chk("noreaccept_mvalid", {31'b0, mem_valid}, 32'd0);
        ifu_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] pc, r, exp;

        // Cold miss then hit
        bmem[0] = 32'h0000_0013;
        do_reset();
        fetch(32'h0, 2);
        fetch(32'h0, 0);

        // Conflict on index 0, then independent fill of index 1
        do_reset();
        bmem[0] = 32'hAAAA_0001;
        bmem[32'h100 >> 2] = 32'hBBBB_0002;
        fetch(32'h000, 1);
        fetch(32'h100, 0);
        fetch(32'h000, 3);
        fetch(32'h104, 1);
        fetch(32'h000, 0);

        // Flush mid-miss with coincident mem_enable
        ifu_valid = 1'b1; ifu_pc = 32'h40;
        step();
        chk("fl_mvalid", {31'b0, mem_valid}, 32'd1);
        step();
        flush = 1'b1; mem_enable = 1'b1; mem_data = 32'hFEED_FACE;
        step();
        flush = 1'b0; mem_enable = 1'b0; ifu_valid = 1'b0;
        chk("fl_mvalid_drop", {31'b0, mem_valid}, 32'd0);
        chk("fl_ready", {31'b0, ifu_ready}, 32'd0);
        step();
        chk("fl_ready_after", {31'b0, ifu_ready}, 32'd0);
        chk("fl_mvalid_after", {31'b0, mem_valid}, 32'd0);
        fetch(32'h40, 1);

        // rdy low during a miss: stray mem_enable and flush must be ignored
        pc = 32'h0000_02C8;
        exp = mem_word(pc);
        ifu_valid = 1'b1; ifu_pc = pc;
        step();
        chk("rdy_mvalid", {31'b0, mem_valid}, 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin mem_enable = 1'b1; mem_data = 32'hDEAD_BEEF; end
            if (i == 3) flush = 1'b1;
            step();
            mem_enable = 1'b0; flush = 1'b0;
            chk("rdy_hold_mvalid", {31'b0, mem_valid}, 32'd1);
            chk("rdy_hold_maddr", mem_addr, pc);
            chk("rdy_hold_ready", {31'b0, ifu_ready}, 32'd0);
        end
        rdy = 1'b1;
        step();
        chk("rdy_nofill_mvalid", {31'b0, mem_valid}, 32'd1);
        chk("rdy_nofill_ready", {31'b0, ifu_ready}, 32'd0);
        mem_enable = 1'b1; mem_data = exp;
        step();
        mem_enable = 1'b0;
        chk("rdy_fill_ready", {31'b0, ifu_ready}, 32'd1);
        chk("rdy_fill_inst", ifu_inst, exp);
        chk("rdy_fill_mvalid", {31'b0, mem_valid}, 32'd0);
        mv[pc[7:2]] = 1'b1; mt[pc[7:2]] = pc[17:8]; md[pc[7:2]] = exp;
        step();
        ifu_valid = 1'b0;
        chk("rdy_done_ready", {31'b0, ifu_ready}, 32'd0);
        fetch(pc, 0);

        // Async reset mid-miss, between clock edges
        fetch(32'h0, 0);
        ifu_valid = 1'b1; ifu_pc = 32'h3F0;
        step();
        chk("ar_mvalid", {31'b0, mem_valid}, 32'd1);
        #3 rst = 1'b0;
        #1;
        chk("ar_ready", {31'b0, ifu_ready}, 32'd0);
        chk("ar_inst", ifu_inst, 32'd0);
        chk("ar_mvalid0", {31'b0, mem_valid}, 32'd0);
        chk("ar_maddr", mem_addr, 32'd0);
        #2 rst = 1'b1;
        clear_model();
        ifu_valid = 1'b0;
        step();
        chk("ar_idle_mvalid", {31'b0, mem_valid}, 32'd0);
        fetch(32'h0, 1);

        // Randomized fetches over a small tag/index pool, with stray enables in idle
        for (int n = 0; n < 80; n++) begin
            r = $urandom;
            pc = {r[31:18], 8'b0, r[3:2], 3'b0, r[6:4], r[8:7]};
            fetch(pc, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                mem_enable = 1'b1; mem_data = $urandom;
                step();
                mem_enable = 1'b0;
                chk("idle_en_ready", {31'b0, ifu_ready}, 32'd0);
                chk("idle_en_mvalid", {31'b0, mem_valid}, 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
